// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register constants for mmio_uart_tx
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_PAR     = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count, push rejected when full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a push into a full FIFO is
    // refused even when a pop frees a slot on the same edge.
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array, no reset needed since reads are gated by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count carries the extra bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter; UART_PARITY_EN adds an even parity bit
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          DIV_RESET  = 434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_PARITY_EN
    localparam logic        PAR_EN     = 1'b1;
    localparam uart_state_t AFTER_DATA = PARITY;
`else
    localparam logic        PAR_EN     = 1'b0;
    localparam uart_state_t AFTER_DATA = STOP;
`endif

    uart_state_t   state;
    logic [7:0]    shreg;
    logic [15:0]   reload;
    logic [15:0]   timer;
    logic [2:0]    bit_idx;
    logic [15:0]   div;
    logic          overflow;

    logic [1:0]    offset;
    logic          wr_en;
    logic          push_req;
    logic          ovf_clr;
    logic          pop;
    logic          timer_done;
    logic          line_bit;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   cnt_ext;
    logic [3:0]    cnt_sat;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = addr[3:2];
    assign wr_en      = we & sel;
    assign push_req   = wr_en & (offset == UART_TXDATA);
    assign ovf_clr    = wr_en & (offset == UART_STATUS) & wdata[3];
    assign timer_done = (timer == 16'd0);
    assign pop        = ~fifo_empty & ((state == IDLE) | ((state == STOP) & timer_done));
    assign cnt_ext    = 32'(fifo_count);
    assign cnt_sat    = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
    assign unused_bits = ^{addr[1:0], wdata[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Status word assembled from live FSM and FIFO state.
    always_comb begin
        status_word              = '0;
        status_word[ST_BUSY]     = (state != IDLE);
        status_word[ST_FULL]     = fifo_full;
        status_word[ST_EMPTY]    = fifo_empty;
        status_word[ST_OVF]      = overflow;
        status_word[ST_CNT_LSB +: 4] = cnt_sat;
        status_word[ST_PAR]      = PAR_EN;
    end

    // Combinational register read, zero outside the window and for TXDATA/reserved.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                UART_STATUS: rdata = status_word;
                UART_DIV:    rdata = {16'd0, div};
                default:     rdata = '0;
            endcase
        end
    end

    // Divider and sticky overflow; a set wins over a clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= 16'(DIV_RESET);
            overflow <= 1'b0;
        end else begin
            if (wr_en && (offset == UART_DIV)) begin
                div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end
            overflow <= (push_req & fifo_full) | (overflow & ~ovf_clr);
        end
    end

    // Level the line should carry for the current state; tx lags it by one register.
    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shreg[bit_idx];
            PARITY:  line_bit = ^shreg;
            default: line_bit = 1'b1;
        endcase
    end

    // Frame sequencer: each state lasts reload cycles, divider latched per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            reload  <= 16'(DIV_RESET);
            timer   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            tx <= line_bit;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg   <= fifo_dout;
                        reload  <= div;
                        timer   <= div - 16'd1;
                        bit_idx <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (timer_done) begin
                        timer <= reload - 16'd1;
                        state <= DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (timer_done) begin
                        timer <= reload - 16'd1;
                        if (bit_idx == 3'd7) begin
                            state <= AFTER_DATA;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                PARITY: begin
                    if (timer_done) begin
                        timer <= reload - 16'd1;
                        state <= STOP;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                STOP: begin
                    if (timer_done) begin
                        if (!fifo_empty) begin
                            shreg   <= fifo_dout;
                            reload  <= div;
                            timer   <= div - 16'd1;
                            bit_idx <= '0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
